// File: rtl/sumador_pkg.sv
// ============================================================================
//  Module      : sumador_pkg
//  Description : Shared constants, FSM encoding and sign-magnitude field
//                helpers for the Sumador adder and its arbiter front end.
//                Number format: bit 31 sign, bits 30:10 integer part,
//                bits 9:0 fraction.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sumador_pkg;

    // Operand/result width and fraction length of the fixed-point format.
    localparam int WIDTH = 32;
    localparam int FRAC  = 10;

    // Magnitude field width (everything below the sign bit).
    localparam int MAG_W = WIDTH - 1;

    // Arbiter sequencer states, explicitly encoded in two bits.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Sign bit of a sign-magnitude word.
    function automatic logic sm_sign(input logic [WIDTH-1:0] v);
        return v[WIDTH-1];
    endfunction

    // Magnitude field of a sign-magnitude word.
    function automatic logic [MAG_W-1:0] sm_mag(input logic [WIDTH-1:0] v);
        return v[MAG_W-1:0];
    endfunction

endpackage : sumador_pkg

`default_nettype wire

// File: rtl/Sumador.sv
// ============================================================================
//  Module      : Sumador
//  Description : Combinational 32-bit sign-magnitude fixed-point adder.
//                Like signs: magnitudes add, sign kept, ovf flags a carry
//                out of the 31-bit magnitude (result magnitude wraps).
//                Unlike signs: smaller magnitude is subtracted from the
//                larger one and the larger operand's sign is kept; on a tie
//                the sign of 'a' is kept, so -x + x yields -0.
//  Ports       : a   in  32  operand A (sign-magnitude)
//                b   in  32  operand B (sign-magnitude)
//                Z   out 32  sum (sign-magnitude)
//                ovf out 1   magnitude overflow
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module Sumador
    import sumador_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] Z,
    output logic             ovf
);

    logic             w_sign_a;
    logic             w_sign_b;
    logic [MAG_W-1:0] w_mag_a;
    logic [MAG_W-1:0] w_mag_b;
    logic             w_same_sign;
    logic             w_a_ge_b;
    // One extra bit so the carry out of the magnitude is visible.
    logic [MAG_W:0]   w_mag_sum;
    logic [MAG_W-1:0] w_mag_diff;

    assign w_sign_a    = sm_sign(a);
    assign w_sign_b    = sm_sign(b);
    assign w_mag_a     = sm_mag(a);
    assign w_mag_b     = sm_mag(b);
    assign w_same_sign = (w_sign_a == w_sign_b);
    assign w_a_ge_b    = (w_mag_a >= w_mag_b);

    assign w_mag_sum   = {1'b0, w_mag_a} + {1'b0, w_mag_b};
    assign w_mag_diff  = w_a_ge_b ? (w_mag_a - w_mag_b) : (w_mag_b - w_mag_a);

    always_comb begin
        Z   = '0;
        ovf = 1'b0;
        if (w_same_sign) begin
            Z   = {w_sign_a, w_mag_sum[MAG_W-1:0]};
            ovf = w_mag_sum[MAG_W];
        end else begin
            // Subtraction can never overflow.
            Z   = {(w_a_ge_b ? w_sign_a : w_sign_b), w_mag_diff};
            ovf = 1'b0;
        end
    end

endmodule : Sumador

`default_nettype wire

// File: rtl/arbitro_sumador.sv
// ============================================================================
//  Module      : arbitro_sumador
//  Description : Two-requester round-robin arbiter and sequencer in front of
//                a single Sumador. One operation is in flight at a time:
//                IDLE (arbitrate/accept) -> CALC (adder evaluates the
//                registered operands, result captured) -> RESP (result held
//                until consumed). Also keeps a saturating count of
//                overflowed additions.
//  Ports       : clk                 in   clock, rising edge
//                rst_n               in   asynchronous active-low reset
//                req{0,1}_valid      in   requester has an operand pair
//                req{0,1}_a/_b       in   sign-magnitude operands
//                req{0,1}_ready      out  request accepted when valid&ready
//                rsp_valid           out  result available
//                rsp_ready           in   consumer takes result
//                rsp_id              out  requester owning the result
//                rsp_z               out  sum
//                rsp_ovf             out  overflow flag of that sum
//                ovf_cnt             out  saturating overflow counter
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbitro_sumador
    import sumador_pkg::arb_state_t;
    import sumador_pkg::IDLE;
    import sumador_pkg::CALC;
    import sumador_pkg::RESP;
#(
    // Must match the Sumador width (32); no other value is supported.
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,

    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_z,
    output logic             rsp_ovf,

    output logic [CNT_W-1:0] ovf_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t       state_q,   state_d;
    logic             last_id_q, last_id_d;
    logic [WIDTH-1:0] op_a_q,    op_a_d;
    logic [WIDTH-1:0] op_b_q,    op_b_d;
    logic             op_id_q,   op_id_d;
    logic [WIDTH-1:0] rsp_z_q,   rsp_z_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic             rsp_id_q,  rsp_id_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    // Adder outputs
    logic [WIDTH-1:0] w_sum_z;
    logic             w_sum_ovf;

    // Arbitration
    logic             w_idle;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;

    // ------------------------------------------------------------------
    // Round-robin arbitration. A lone valid always wins; on a tie the
    // requester that was not granted last wins. The grants are mutually
    // exclusive by construction, so at most one ready is ever high.
    // ------------------------------------------------------------------
    assign w_idle   = (state_q == IDLE);
    assign w_grant0 = req0_valid && (!req1_valid ||  last_id_q);
    assign w_grant1 = req1_valid && (!req0_valid || !last_id_q);
    assign w_accept = w_idle && (w_grant0 || w_grant1);

    assign req0_ready = w_idle && w_grant0;
    assign req1_ready = w_idle && w_grant1;

    // ------------------------------------------------------------------
    // The single adder sees only the registered operands.
    // ------------------------------------------------------------------
    Sumador u_sumador (
        .a   (op_a_q),
        .b   (op_b_q),
        .Z   (w_sum_z),
        .ovf (w_sum_ovf)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        last_id_d = last_id_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        op_id_d   = op_id_q;
        rsp_z_d   = rsp_z_q;
        rsp_ovf_d = rsp_ovf_q;
        rsp_id_d  = rsp_id_q;
        ovf_cnt_d = ovf_cnt_q;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    // Grant 1 wins the mux only when it is the granted one.
                    op_a_d    = w_grant1 ? req1_a : req0_a;
                    op_b_d    = w_grant1 ? req1_b : req0_b;
                    op_id_d   = w_grant1;
                    last_id_d = w_grant1;
                    state_d   = CALC;
                end
            end

            CALC: begin
                rsp_z_d   = w_sum_z;
                rsp_ovf_d = w_sum_ovf;
                rsp_id_d  = op_id_q;
                if (w_sum_ovf && (ovf_cnt_q != {CNT_W{1'b1}})) begin
                    ovf_cnt_d = ovf_cnt_q + CNT_ONE;
                end
                state_d = RESP;
            end

            RESP: begin
                // Response fields are simply not written here, which keeps
                // them stable for as long as the consumer stalls.
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_id_q <= 1'b1;      // requester 0 wins the first tie
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_id_q   <= 1'b0;
            rsp_z_q   <= '0;
            rsp_ovf_q <= 1'b0;
            rsp_id_q  <= 1'b0;
            ovf_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            last_id_q <= last_id_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            op_id_q   <= op_id_d;
            rsp_z_q   <= rsp_z_d;
            rsp_ovf_q <= rsp_ovf_d;
            rsp_id_q  <= rsp_id_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rsp_valid = (state_q == RESP);
    assign rsp_z     = rsp_z_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign rsp_id    = rsp_id_q;
    assign ovf_cnt   = ovf_cnt_q;

endmodule : arbitro_sumador

`default_nettype wire
